// File: rtl/ctrl_axil_to_shim_bridge.sv
// AXI4-Lite (host control) to single-beat AXI4 (F1Shim io_master) bridge with address window
// check, response timeout and late-response draining. One transaction outstanding at a time.
module ctrl_axil_to_shim_bridge #(
   parameter int unsigned ADDR_WIDTH     = 25,
   parameter int unsigned ID_WIDTH       = 12,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  s_axil_awvalid_i,
   output logic                  s_axil_awready_o,
   input  logic [31:0]           s_axil_awaddr_i,
   input  logic                  s_axil_wvalid_i,
   output logic                  s_axil_wready_o,
   input  logic [31:0]           s_axil_wdata_i,
   input  logic [3:0]            s_axil_wstrb_i,
   output logic                  s_axil_bvalid_o,
   input  logic                  s_axil_bready_i,
   output logic [1:0]            s_axil_bresp_o,
   input  logic                  s_axil_arvalid_i,
   output logic                  s_axil_arready_o,
   input  logic [31:0]           s_axil_araddr_i,
   output logic                  s_axil_rvalid_o,
   input  logic                  s_axil_rready_i,
   output logic [31:0]           s_axil_rdata_o,
   output logic [1:0]            s_axil_rresp_o,
   output logic                  m_axi_awvalid_o,
   input  logic                  m_axi_awready_i,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr_o,
   output logic [7:0]            m_axi_awlen_o,
   output logic [2:0]            m_axi_awsize_o,
   output logic [1:0]            m_axi_awburst_o,
   output logic [ID_WIDTH-1:0]   m_axi_awid_o,
   output logic                  m_axi_wvalid_o,
   input  logic                  m_axi_wready_i,
   output logic [31:0]           m_axi_wdata_o,
   output logic [3:0]            m_axi_wstrb_o,
   output logic                  m_axi_wlast_o,
   input  logic                  m_axi_bvalid_i,
   output logic                  m_axi_bready_o,
   input  logic [1:0]            m_axi_bresp_i,
   output logic                  m_axi_arvalid_o,
   input  logic                  m_axi_arready_i,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
   output logic [7:0]            m_axi_arlen_o,
   output logic [2:0]            m_axi_arsize_o,
   output logic [1:0]            m_axi_arburst_o,
   output logic [ID_WIDTH-1:0]   m_axi_arid_o,
   input  logic                  m_axi_rvalid_i,
   output logic                  m_axi_rready_o,
   input  logic [31:0]           m_axi_rdata_i,
   input  logic [1:0]            m_axi_rresp_i,
   input  logic                  m_axi_rlast_i,
   output logic [15:0]           timeout_count_o
);

   localparam int unsigned TcntW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [1:0]  RespSlvErr = 2'b10;
   localparam logic [1:0]  RespDecErr = 2'b11;

   typedef enum logic [2:0] {StIdle, StWIssue, StWWait, StRIssue, StRWait, StBResp, StRResp} state_e;

   state_e                state_q, state_d;
   logic                  prio_rd_q;  // 1: read wins the next contested arbitration
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q, rdata_q;
   logic [3:0]            wstrb_q;
   logic                  awvalid_q, wvalid_q, arvalid_q, bvalid_q, rvalid_q;
   logic [1:0]            bresp_q, rresp_q;
   logic [TcntW-1:0]      tcnt_q;
   logic [15:0]           tmo_count_q;
   logic                  drain_b_q, drain_r_q;

   logic w_elig, r_elig, grant_w, grant_r, win_w, win_r, tmo;
   logic unused_rlast;

   assign unused_rlast = m_axi_rlast_i;
   assign w_elig  = s_axil_awvalid_i && s_axil_wvalid_i && !drain_b_q;
   assign r_elig  = s_axil_arvalid_i && !drain_r_q;
   assign grant_w = w_elig && (!r_elig || !prio_rd_q);
   assign grant_r = r_elig && !grant_w;
   assign win_w   = (s_axil_awaddr_i[31:ADDR_WIDTH] == '0);
   assign win_r   = (s_axil_araddr_i[31:ADDR_WIDTH] == '0);
   assign tmo     = (tcnt_q == TcntW'(TIMEOUT_CYCLES));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (grant_w)      state_d = win_w ? StWIssue : StBResp;
            else if (grant_r) state_d = win_r ? StRIssue : StRResp;
         end
         StWIssue: begin
            if ((!awvalid_q || m_axi_awready_i) && (!wvalid_q || m_axi_wready_i)) state_d = StWWait;
         end
         StWWait:  if (m_axi_bvalid_i || tmo) state_d = StBResp;
         StRIssue: if (m_axi_arready_i) state_d = StRWait;
         StRWait:  if (m_axi_rvalid_i || tmo) state_d = StRResp;
         StBResp:  if (s_axil_bready_i) state_d = StIdle;
         StRResp:  if (s_axil_rready_i) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Readies are gated by reset so they drop asynchronously along with the registered valids.
   always_comb begin
      s_axil_awready_o = !reset && (state_q == StIdle) && grant_w;
      s_axil_wready_o  = s_axil_awready_o;
      s_axil_arready_o = !reset && (state_q == StIdle) && grant_r;
      m_axi_bready_o   = !reset && ((state_q == StWWait) || drain_b_q);
      m_axi_rready_o   = !reset && ((state_q == StRWait) || drain_r_q);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prio_rd_q <= 1'b0;  addr_q    <= '0;    wdata_q   <= '0;    wstrb_q  <= '0;
         rdata_q   <= '0;    awvalid_q <= 1'b0;  wvalid_q  <= 1'b0;  arvalid_q <= 1'b0;
         bvalid_q  <= 1'b0;  rvalid_q  <= 1'b0;  bresp_q   <= '0;    rresp_q  <= '0;
         tcnt_q    <= '0;    tmo_count_q <= '0;  drain_b_q <= 1'b0;  drain_r_q <= 1'b0;
      end else begin
         if (state_q == StWWait || state_q == StRWait) tcnt_q <= tcnt_q + TcntW'(1);
         else                                          tcnt_q <= '0;
         if (drain_b_q && m_axi_bvalid_i) drain_b_q <= 1'b0;
         if (drain_r_q && m_axi_rvalid_i) drain_r_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (w_elig && r_elig) prio_rd_q <= grant_w;
               if (grant_w) begin
                  addr_q  <= s_axil_awaddr_i[ADDR_WIDTH-1:0];
                  wdata_q <= s_axil_wdata_i;
                  wstrb_q <= s_axil_wstrb_i;
                  if (win_w) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else begin
                     bvalid_q <= 1'b1;
                     bresp_q  <= RespDecErr;
                  end
               end else if (grant_r) begin
                  addr_q <= s_axil_araddr_i[ADDR_WIDTH-1:0];
                  if (win_r) begin
                     arvalid_q <= 1'b1;
                  end else begin
                     rvalid_q <= 1'b1;
                     rresp_q  <= RespDecErr;
                     rdata_q  <= '0;
                  end
               end
            end
            StWIssue: begin
               if (m_axi_awready_i) awvalid_q <= 1'b0;
               if (m_axi_wready_i)  wvalid_q  <= 1'b0;
            end
            StWWait: begin
               if (m_axi_bvalid_i) begin
                  bvalid_q <= 1'b1;
                  bresp_q  <= m_axi_bresp_i;
               end else if (tmo) begin
                  bvalid_q  <= 1'b1;
                  bresp_q   <= RespSlvErr;
                  drain_b_q <= 1'b1;
                  if (tmo_count_q != 16'hffff) tmo_count_q <= tmo_count_q + 16'd1;
               end
            end
            StRIssue: if (m_axi_arready_i) arvalid_q <= 1'b0;
            StRWait: begin
               if (m_axi_rvalid_i) begin
                  rvalid_q <= 1'b1;
                  rresp_q  <= m_axi_rresp_i;
                  rdata_q  <= m_axi_rdata_i;
               end else if (tmo) begin
                  rvalid_q  <= 1'b1;
                  rresp_q   <= RespSlvErr;
                  rdata_q   <= '0;
                  drain_r_q <= 1'b1;
                  if (tmo_count_q != 16'hffff) tmo_count_q <= tmo_count_q + 16'd1;
               end
            end
            StBResp: if (s_axil_bready_i) bvalid_q <= 1'b0;
            StRResp: if (s_axil_rready_i) rvalid_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign s_axil_bvalid_o = bvalid_q;
   assign s_axil_bresp_o  = bresp_q;
   assign s_axil_rvalid_o = rvalid_q;
   assign s_axil_rdata_o  = rdata_q;
   assign s_axil_rresp_o  = rresp_q;
   assign m_axi_awvalid_o = awvalid_q;
   assign m_axi_awaddr_o  = addr_q;
   assign m_axi_awlen_o   = 8'd0;
   assign m_axi_awsize_o  = 3'h2;
   assign m_axi_awburst_o = 2'h1;
   assign m_axi_awid_o    = '0;
   assign m_axi_wvalid_o  = wvalid_q;
   assign m_axi_wdata_o   = wdata_q;
   assign m_axi_wstrb_o   = wstrb_q;
   assign m_axi_wlast_o   = 1'b1;
   assign m_axi_arvalid_o = arvalid_q;
   assign m_axi_araddr_o  = addr_q;
   assign m_axi_arlen_o   = 8'd0;
   assign m_axi_arsize_o  = 3'h2;
   assign m_axi_arburst_o = 2'h1;
   assign m_axi_arid_o    = '0;
   assign timeout_count_o = tmo_count_q;

endmodule

// File: tb/tb_ctrl_axil_to_shim_bridge.sv
// Directed bench for ctrl_axil_to_shim_bridge: window check, arbitration, timeout/drain,
// backpressure and asynchronous reset, with hand-computed expectations.
module tb_ctrl_axil_to_shim_bridge;

   localparam int unsigned AW = 25;
   localparam int unsigned IW = 12;

   logic clock = 1'b0;
   logic reset;
   logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic s_arvalid, s_arready, s_rvalid, s_rready;
   logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  s_bresp, s_rresp;
   logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
   logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
   logic [AW-1:0] m_awaddr, m_araddr;
   logic [7:0]    m_awlen, m_arlen;
   logic [2:0]    m_awsize, m_arsize;
   logic [1:0]    m_awburst, m_arburst, m_bresp, m_rresp;
   logic [IW-1:0] m_awid, m_arid;
   logic [31:0]   m_wdata, m_rdata;
   logic [3:0]    m_wstrb;
   logic [15:0]   timeout_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   ctrl_axil_to_shim_bridge #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(8)) dut (
      .clock(clock), .reset(reset),
      .s_axil_awvalid_i(s_awvalid), .s_axil_awready_o(s_awready), .s_axil_awaddr_i(s_awaddr),
      .s_axil_wvalid_i(s_wvalid), .s_axil_wready_o(s_wready), .s_axil_wdata_i(s_wdata),
      .s_axil_wstrb_i(s_wstrb),
      .s_axil_bvalid_o(s_bvalid), .s_axil_bready_i(s_bready), .s_axil_bresp_o(s_bresp),
      .s_axil_arvalid_i(s_arvalid), .s_axil_arready_o(s_arready), .s_axil_araddr_i(s_araddr),
      .s_axil_rvalid_o(s_rvalid), .s_axil_rready_i(s_rready), .s_axil_rdata_o(s_rdata),
      .s_axil_rresp_o(s_rresp),
      .m_axi_awvalid_o(m_awvalid), .m_axi_awready_i(m_awready), .m_axi_awaddr_o(m_awaddr),
      .m_axi_awlen_o(m_awlen), .m_axi_awsize_o(m_awsize), .m_axi_awburst_o(m_awburst),
      .m_axi_awid_o(m_awid),
      .m_axi_wvalid_o(m_wvalid), .m_axi_wready_i(m_wready), .m_axi_wdata_o(m_wdata),
      .m_axi_wstrb_o(m_wstrb), .m_axi_wlast_o(m_wlast),
      .m_axi_bvalid_i(m_bvalid), .m_axi_bready_o(m_bready), .m_axi_bresp_i(m_bresp),
      .m_axi_arvalid_o(m_arvalid), .m_axi_arready_i(m_arready), .m_axi_araddr_o(m_araddr),
      .m_axi_arlen_o(m_arlen), .m_axi_arsize_o(m_arsize), .m_axi_arburst_o(m_arburst),
      .m_axi_arid_o(m_arid),
      .m_axi_rvalid_i(m_rvalid), .m_axi_rready_o(m_rready), .m_axi_rdata_i(m_rdata),
      .m_axi_rresp_i(m_rresp), .m_axi_rlast_i(m_rlast),
      .timeout_count_o(timeout_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clock);
   endtask

   // Waits (bounded) for s_bvalid, checks resp, then completes the upstream handshake.
   task automatic finish_write(input string tag, input logic [1:0] resp);
      int n = 0;
      while (!s_bvalid && n < 50) begin cyc(); n++; end
      check_eq({tag, "_bvalid"}, 32'(s_bvalid), 32'd1);
      check_eq({tag, "_bresp"}, 32'(s_bresp), 32'(resp));
      s_bready = 1'b1;
      cyc();
      s_bready = 1'b0;
   endtask

   task automatic finish_read(input string tag, input logic [1:0] resp, input logic [31:0] data);
      int n = 0;
      while (!s_rvalid && n < 50) begin cyc(); n++; end
      check_eq({tag, "_rvalid"}, 32'(s_rvalid), 32'd1);
      check_eq({tag, "_rresp"}, 32'(s_rresp), 32'(resp));
      check_eq({tag, "_rdata"}, s_rdata, data);
      s_rready = 1'b1;
      cyc();
      s_rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
      s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
      m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 1;
      repeat (3) cyc();
      check_eq("rst_valids", {s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid}, 0);
      check_eq("rst_readies", {s_awready, s_wready, s_arready, m_bready, m_rready}, 0);
      check_eq("rst_tmo_count", 32'(timeout_count), 0);
      reset = 1'b0;
      cyc();

      // Write in window, B arrives two cycles into W_WAIT
      s_awvalid = 1; s_wvalid = 1; s_awaddr = 32'h10; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
      m_awready = 1; m_wready = 1;
      #1 check_eq("wr_awready", {s_awready, s_wready}, 32'b11);
      cyc();
      s_awvalid = 0; s_wvalid = 0;
      check_eq("wr_m_valids", {m_awvalid, m_wvalid}, 32'b11);
      check_eq("wr_m_awaddr", 32'(m_awaddr), 32'h10);
      check_eq("wr_m_awfields", {m_awlen, m_awsize, m_awburst, m_awid}, {8'd0, 3'h2, 2'h1, 12'd0});
      check_eq("wr_m_wdata", m_wdata, 32'hDEADBEEF);
      check_eq("wr_m_wstrb_last", {m_wstrb, m_wlast}, 32'b11111);
      cyc();
      check_eq("wr_wait", {m_awvalid, m_wvalid, m_bready, s_bvalid}, 32'b0010);
      cyc();
      check_eq("wr_no_early_b", 32'(s_bvalid), 0);
      m_bvalid = 1; m_bresp = 2'b00;
      cyc();
      m_bvalid = 0;
      check_eq("wr_b_latency", 32'(s_bvalid), 1);
      finish_write("wr", 2'b00);

      // Out-of-window write then read: answered locally with DECERR
      s_awvalid = 1; s_wvalid = 1; s_awaddr = 32'h0200_0000; s_wdata = 32'h1;
      cyc();
      s_awvalid = 0; s_wvalid = 0;
      check_eq("oow_w_no_fwd", {m_awvalid, m_wvalid, m_arvalid}, 0);
      check_eq("oow_w_bvalid", 32'(s_bvalid), 1);
      finish_write("oow_w", 2'b11);
      s_arvalid = 1; s_araddr = 32'h0200_0000;
      cyc();
      s_arvalid = 0;
      check_eq("oow_r_no_fwd", {m_awvalid, m_arvalid}, 0);
      check_eq("oow_r_rvalid", 32'(s_rvalid), 1);
      finish_read("oow_r", 2'b11, 32'h0);

      // Simultaneous write and read, twice; priority flips only on contention
      m_arready = 1; m_bvalid = 1; m_bresp = 2'b00; m_rvalid = 1; m_rdata = 32'hCAFEF00D;
      s_awvalid = 1; s_wvalid = 1; s_awaddr = 32'h20; s_wdata = 32'h11112222;
      s_arvalid = 1; s_araddr = 32'h30;
      #1 check_eq("pair1_grant", {s_awready, s_arready}, 32'b10);
      cyc();
      s_awvalid = 0; s_wvalid = 0;
      check_eq("pair1_w_first", {m_awvalid, m_arvalid}, 32'b10);
      finish_write("pair1_w", 2'b00);
      check_eq("pair1_r_next", {s_awready, s_arready}, 32'b01);
      cyc();
      s_arvalid = 0;
      check_eq("pair1_m_araddr", 32'(m_araddr), 32'h30);
      finish_read("pair1_r", 2'b00, 32'hCAFEF00D);
      s_awvalid = 1; s_wvalid = 1; s_awaddr = 32'h24; s_arvalid = 1; s_araddr = 32'h34;
      #1 check_eq("pair2_grant", {s_awready, s_arready}, 32'b01);
      cyc();
      s_arvalid = 0;
      finish_read("pair2_r", 2'b00, 32'hCAFEF00D);
      check_eq("pair2_w_next", 32'(s_awready), 1);
      cyc();
      s_awvalid = 0; s_wvalid = 0;
      finish_write("pair2_w", 2'b00);
      m_bvalid = 0; m_rvalid = 0;

      // Read timeout (8 cycles) and drain of the late R beat
      s_arvalid = 1; s_araddr = 32'h40;
      cyc();
      s_arvalid = 0;
      check_eq("tmo_arvalid", 32'(m_arvalid), 1);
      cyc();
      check_eq("tmo_wait_entry", {m_arvalid, m_rready}, 32'b01);
      repeat (8) cyc();
      check_eq("tmo_not_yet", 32'(s_rvalid), 0);
      cyc();
      check_eq("tmo_rvalid", 32'(s_rvalid), 1);
      check_eq("tmo_count", 32'(timeout_count), 1);
      check_eq("tmo_drain_rready", 32'(m_rready), 1);
      finish_read("tmo", 2'b10, 32'h0);
      s_arvalid = 1; s_araddr = 32'h44;
      #1 check_eq("drain_blocks_read", 32'(s_arready), 0);
      cyc();
      check_eq("drain_still_blocked", {s_arready, m_arvalid}, 0);
      m_rvalid = 1; m_rdata = 32'hBAD0BAD0; m_rresp = 2'b00;
      cyc();
      m_rvalid = 0;
      check_eq("drain_not_fwd", 32'(s_rvalid), 0);
      check_eq("drain_cleared", {m_rready, s_arready}, 32'b01);
      cyc();
      s_arvalid = 0;
      m_rvalid = 1; m_rdata = 32'h12345678;
      finish_read("post_drain", 2'b00, 32'h12345678);
      m_rvalid = 0;

      // AW backpressure for 10 cycles with W accepted immediately
      m_awready = 0; m_wready = 1;
      s_awvalid = 1; s_wvalid = 1; s_awaddr = 32'h50; s_wdata = 32'hA5A5A5A5;
      cyc();
      s_awvalid = 0; s_wvalid = 0;
      check_eq("bp_first", {m_awvalid, m_wvalid}, 32'b11);
      for (int i = 0; i < 9; i++) begin
         cyc();
         check_eq("bp_hold", {m_awvalid, m_wvalid, 7'(m_awaddr)}, {2'b10, 7'h50});
      end
      m_awready = 1;
      cyc();
      check_eq("bp_wait", {m_awvalid, m_bready}, 32'b01);
      cyc();

      // Asynchronous reset in W_WAIT
      reset = 1; s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_awaddr = 32'h60;
      #1 check_eq("arst_valids", {s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid}, 0);
      check_eq("arst_readies", {s_awready, s_wready, s_arready, m_bready, m_rready}, 0);
      check_eq("arst_tmo_count", 32'(timeout_count), 0);
      cyc();
      reset = 0;
      #1 check_eq("arst_idle_grant", {s_awready, s_arready}, 32'b10);
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      repeat (2) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_axil_to_shim_bridge.md
# ctrl_axil_to_shim_bridge

Single-clock bridge between the PCIe host AXI4-Lite control master and the F1Shim AXI4 control slave port (`io_master_*`). Converts each AXI4-Lite access into a single-beat AXI4 transaction and truncates the address to the shim's window. Rejects out-of-window addresses locally. Bounds response latency with a timeout so that a hung shim cannot stall the host driver. One transaction is outstanding at a time; write/read arbitration is round-robin.

## Interface
- `ADDR_WIDTH`, 25: downstream address width; upstream bits [31:ADDR_WIDTH] must be zero.
- `ID_WIDTH`, 12: downstream AXI ID width; the ID is driven to 0.
- `TIMEOUT_CYCLES`, 4096: maximum number of cycles to wait for a downstream B/R before answering locally.
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `s_axil_aw{valid,ready,addr[31:0]}`, `s_axil_w{valid,ready,data[31:0],strb[3:0]}`, `s_axil_b{valid,ready,resp[1:0]}`: upstream write channels. The upstream side is the slave.
- `s_axil_ar{valid,ready,addr[31:0]}`, `s_axil_r{valid,ready,data[31:0],resp[1:0]}`: upstream read channels.
- `m_axi_aw{valid,ready,addr[ADDR_WIDTH-1:0],len[7:0],size[2:0],burst[1:0],id[ID_WIDTH-1:0]}`: downstream write-address channel. The downstream side is the master.
- `m_axi_w{valid,ready,data[31:0],strb[3:0],last}`: downstream write-data channel.
- `m_axi_b{valid,ready,resp[1:0]}`: downstream write-response channel.
- `m_axi_ar{...same fields as aw}`: downstream read-address channel.
- `m_axi_r{valid,ready,data[31:0],resp[1:0],last}`: downstream read-data channel.
- `timeout_count` out 16: saturating count of timed-out transactions.

## Operation
- **Constant downstream fields:** len=0, size=3'h2, burst=2'h1 (INCR), id=0, wlast=1. Incoming `m_axi_r.last` is ignored.
- **FSM states:** IDLE, W_ISSUE, W_WAIT, R_ISSUE, R_WAIT, B_RESP, R_RESP.
- **IDLE, write eligibility:** a write is eligible only when awvalid and wvalid are both high. The bridge accepts AW and W in the same cycle; awready equals wready.
- **IDLE, read eligibility:** a read is eligible when arvalid is high.
- **Arbitration when both are eligible:** the channel not granted last wins. The priority bit resets to "write wins".
- **Ready generation:** readies are combinational from state, priority and valids. They are high only in IDLE, and only for the granted channel.
- **Write, address in window:** latch addr, data and strb, then go to W_ISSUE. m_awvalid and m_wvalid assert together. Each drops after its own handshake. Once both have completed, go to W_WAIT.
- **W_WAIT:** m_bready=1. On the m_b handshake, latch bresp and go to B_RESP.
- **Read path:** mirrors the write path through R_ISSUE and R_WAIT. On the m_r handshake, latch rdata and rresp.
- **Address out of window:** any upstream addr[31:ADDR_WIDTH] ≠ 0 is not forwarded. The FSM goes straight to B_RESP or R_RESP with resp=2'b11 (DECERR) and rdata=0.
- **Timeout:** the counter clears on entry to W_WAIT or R_WAIT and increments each cycle in those states. On reaching TIMEOUT_CYCLES:
  - respond resp=2'b10 (SLVERR), with rdata=0 for reads;
  - increment timeout_count;
  - set `drain_b` or `drain_r`.
- **ISSUE states:** never time out; valid is held until accepted, as AXI requires.
- **Draining late responses:** while `drain_b` is set, m_bready=1 in every state. The next m_b beat is discarded and clears `drain_b`. `drain_r` behaves the same way for the R channel.
- **Drain interaction with new transactions:** a new write may not leave IDLE while `drain_b` is set; a new read likewise while `drain_r` is set. The other direction may proceed.
- **B_RESP / R_RESP:** s_bvalid (or s_rvalid) stays high with stable resp/data until the upstream ready. The FSM then returns to IDLE.
- **Reset mid-transaction:** all state is abandoned. All valids and readies drop immediately (asynchronously), and the drain flags clear.

## Timing
- **Reset values:**
  - all `*valid` = 0 and all `*ready` = 0;
  - data/resp/addr registers = 0;
  - state = IDLE, priority = write;
  - timeout counter = 0, timeout_count = 0.
- **Write path, handshake at edge E:** m_awvalid and m_wvalid are high from E+1.
- **Write path, downstream B handshake at edge F:** s_bvalid is high from F+1.
- **Minimum write latency:** upstream accept to s_bvalid is 3 cycles when downstream ready/b are immediate. Reads have the same latency.
- **DECERR:** s_bvalid/s_rvalid is high in the cycle after accept.
- **Timeout:** the SLVERR response asserts exactly TIMEOUT_CYCLES+1 cycles after W_WAIT/R_WAIT entry.
- **Throughput:** back-to-back transactions need one IDLE cycle between the upstream response handshake and the next accept.
- **Registered outputs:** all valids and payloads are registered. Readies are combinational as defined above.

## Test plan
- **Write in window:** write addr 0x0000_0010, data 0xDEADBEEF, strb 0xF, with downstream ready and bresp=0 after 2 cycles.
  - m_aw: addr 0x10, len 0, size 2.
  - m_w: data 0xDEADBEEF, wlast=1.
  - s_bresp=0, with s_bvalid 1 cycle after m_b.
- **Out-of-window accesses:** write to addr 0x0200_0000, then read from it.
  - No m_awvalid or m_arvalid ever asserts.
  - s_bresp=3 and s_rresp=3, rdata=0, each 1 cycle after accept.
- **Simultaneous write and read:** present a write and a read together in IDLE, twice in a row.
  - First pair: write granted first, then read.
  - Second pair: read granted first.
- **Timeout and drain:** TIMEOUT_CYCLES=8; read whose m_r never arrives.
  - s_rresp=2 and rdata=0, 9 cycles after R_WAIT entry; timeout_count=1.
  - Late m_r beat is then consumed (m_rready=1) and not forwarded.
  - A new read is blocked until the drain completes.
- **Backpressure and reset:**
  - Hold m_awready low for 10 cycles with m_wready=1: m_wvalid drops after 1 cycle; m_awvalid stays high with stable addr.
  - Assert reset mid-W_WAIT: all valids are 0 within the same cycle, and state is IDLE after release.
